// File: rtl/regfile_arbiter.sv
// Register-file port arbiter: shares A1/A3 between the pipeline (ID read, WB write)
// and a four-phase debug port, masks x0 writes and bounds debug write starvation.
module regfile_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic [4:0]  id_a1,
    input  logic [31:0] rf_rd1,
    output logic [4:0]  rf_a1,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd3,
    output logic        rf_we3,
    output logic        pipe_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic        dbg_busy
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [CW-1:0]  cnt_r;
    logic [CW-1:0]  cnt_s;
    logic           op_we_r;
    logic [4:0]     op_addr_r;
    logic [31:0]    op_wdata_r;
    logic           ack_r;
    logic           ack_s;
    logic [31:0]    rdata_r;
    logic [31:0]    rdata_s;
    logic           cap_s;
    logic           wb_busy_s;

    assign wb_busy_s = wb_we && (wb_addr != 5'd0);

    // Handshake state, starvation counter, captured debug op and registered debug outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CW{1'b0}};
            op_we_r    <= 1'b0;
            op_addr_r  <= 5'd0;
            op_wdata_r <= 32'd0;
            ack_r      <= 1'b0;
            rdata_r    <= 32'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ack_r   <= ack_s;
            rdata_r <= rdata_s;
            if (cap_s) begin
                op_we_r    <= dbg_we;
                op_addr_r  <= dbg_addr;
                op_wdata_r <= dbg_wdata;
            end
        end
    end

    // Next-state logic and register-file port steering
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        ack_s      = ack_r;
        rdata_s    = rdata_r;
        cap_s      = 1'b0;
        rf_a1      = id_a1;
        rf_a3      = wb_addr;
        rf_wd3     = wb_data;
        rf_we3     = wb_busy_s;
        pipe_stall = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (dbg_req) begin
                    cap_s   = 1'b1;
                    cnt_s   = {CW{1'b0}};
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!op_we_r) begin
                    // Reads borrow A1 for one stalled cycle; WB keeps its write port
                    pipe_stall = 1'b1;
                    rf_a1      = op_addr_r;
                    rdata_s    = (op_addr_r == 5'd0) ? 32'd0 : rf_rd1;
                    ack_s      = 1'b1;
                    state_s    = ST_ACK;
                end else if (op_addr_r == 5'd0) begin
                    ack_s   = 1'b1;
                    state_s = ST_ACK;
                end else if (!wb_busy_s || (cnt_r == CNT_MAX)) begin
                    // A busy WB here means the starvation bound is hit: block WB for one cycle
                    pipe_stall = wb_busy_s;
                    rf_a3      = op_addr_r;
                    rf_wd3     = op_wdata_r;
                    rf_we3     = 1'b1;
                    ack_s      = 1'b1;
                    state_s    = ST_ACK;
                end else begin
                    cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_ACK: begin
                if (!dbg_req) begin
                    ack_s   = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ACK;
                end
            end
            default: begin
                ack_s   = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    assign dbg_ack   = ack_r;
    assign dbg_rdata = rdata_r;
    assign dbg_busy  = (state_r != ST_IDLE);

endmodule
